// File: rtl/codma_rst_seq.sv
// Purpose : staggered per-domain reset sequencer with masked software reset.
// Latency : hw release of domain k after edge SYNC_STAGES+HOLD_CYCLES+k*STAGGER_CYCLES; sw release HOLD_CYCLES after request.
// Backpressure: none; software requests outside READY (or with an empty mask) are dropped without ack.
//
// Ports:
//   clk_i          single system clock
//   reset_n_i      board reset, asynchronous assert, synchronised release
//   sw_rst_req_i   single-cycle software reset request
//   sw_rst_mask_i  domains targeted by sw_rst_req_i
//   rst_n_o        per-domain active-low resets, all flop-driven
//   sw_rst_ack_o   one-cycle pulse when a request is accepted
//   ready_o        all domains out of reset and sequencer idle
module codma_rst_seq #(
    parameter int N_CH           = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            sw_rst_req_i,
    input  logic [N_CH-1:0] sw_rst_mask_i,
    output logic [N_CH-1:0] rst_n_o,
    output logic            sw_rst_ack_o,
    output logic            ready_o
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int STAG_W  = $clog2(STAGGER_CYCLES + 1);
    localparam int CNT_W   = (HOLD_W > STAG_W) ? HOLD_W : STAG_W;
    localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    // The state register acts as the final synchroniser stage, so the
    // explicit chain is one flop shorter than SYNC_STAGES.
    localparam int SYNC_W  = SYNC_STAGES - 1;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_HOLD,
        ST_RELEASE,
        ST_READY
    } state_t;

    state_t             state;
    logic [SYNC_W-1:0]  sync_q;
    logic [N_CH-1:0]    tgt_mask;
    logic [IDX_W-1:0]   rel_idx;
    logic [CNT_W-1:0]   cnt;

    logic [IDX_W-1:0]   low_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               next_found;

    // Lowest set bit of the target mask, and the lowest set bit strictly
    // above the most recently released channel. Scanning downward lets the
    // lowest qualifying index overwrite any higher one.
    always_comb begin
        low_idx    = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (tgt_mask[i]) begin
                low_idx = IDX_W'(i);
            end
            if (tgt_mask[i] && (i > int'(rel_idx))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= ST_SYNC;
            sync_q       <= '0;
            tgt_mask     <= '1;
            rel_idx      <= '0;
            cnt          <= '0;
            rst_n_o      <= '0;
            sw_rst_ack_o <= 1'b0;
            ready_o      <= 1'b0;
        end else begin
            sync_q       <= (sync_q << 1) | SYNC_W'(1);
            sw_rst_ack_o <= 1'b0;

            case (state)
                ST_SYNC: begin
                    if (sync_q[SYNC_W-1]) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                end

                ST_HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state            <= ST_RELEASE;
                        rel_idx          <= low_idx;
                        rst_n_o[low_idx] <= 1'b1;
                        cnt              <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    // Nothing left above the last released channel: idle
                    // one edge after the final release.
                    if (!next_found) begin
                        state   <= ST_READY;
                        ready_o <= 1'b1;
                    end else if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
                        rst_n_o[next_idx] <= 1'b1;
                        rel_idx           <= next_idx;
                        cnt               <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_READY: begin
                    if (sw_rst_req_i && (|sw_rst_mask_i)) begin
                        tgt_mask     <= sw_rst_mask_i;
                        rst_n_o      <= rst_n_o & ~sw_rst_mask_i;
                        sw_rst_ack_o <= 1'b1;
                        ready_o      <= 1'b0;
                        state        <= ST_HOLD;
                        cnt          <= '0;
                    end
                end

                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codma_rst_seq.sv
module tb_codma_rst_seq;

    logic       clk;
    logic       reset_n;
    logic       sw_req;
    logic [3:0] sw_mask;
    logic [3:0] rst_n;
    logic       ack;
    logic       ready;

    logic       reset1_n;
    logic       sw_req1;
    logic [0:0] sw_mask1;
    logic [0:0] rst1_n;
    logic       ack1;
    logic       ready1;

    int n_vec;
    int n_err;
    int edge_no;

    codma_rst_seq #(
        .N_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(4)
    ) u_dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .sw_rst_req_i (sw_req),
        .sw_rst_mask_i(sw_mask),
        .rst_n_o      (rst_n),
        .sw_rst_ack_o (ack),
        .ready_o      (ready)
    );

    codma_rst_seq #(
        .N_CH(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
    ) u_dut1 (
        .clk_i        (clk),
        .reset_n_i    (reset1_n),
        .sw_rst_req_i (sw_req1),
        .sw_rst_mask_i(sw_mask1),
        .rst_n_o      (rst1_n),
        .sw_rst_ack_o (ack1),
        .ready_o      (ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    // Advance to just after edge e of the current sequence.
    task automatic step_to(input int e);
        while (edge_no < e) begin
            @(posedge clk);
            edge_no++;
        end
        #1;
    endtask

    // Drive a request so that it is sampled at edge e.
    task automatic req_at(input int e, input logic [3:0] m);
        step_to(e - 1);
        sw_req  = 1'b1;
        sw_mask = m;
        step_to(e);
        sw_req  = 1'b0;
        sw_mask = 4'b0000;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        edge_no  = 0;
        reset_n  = 1'b0;
        reset1_n = 1'b0;
        sw_req   = 1'b0;
        sw_mask  = 4'b0000;
        sw_req1  = 1'b0;
        sw_mask1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_reset",   32'(rst_n), 32'h0);
        chk("ready_reset", 32'(ready), 32'h0);
        chk("ack_reset",   32'(ack),   32'h0);

        // Power-on sequence, interrupted mid-RELEASE at edge 24.
        @(negedge clk);
        reset_n = 1'b1;
        edge_no = 0;
        step_to(17); chk("po1_e17", 32'(rst_n), 32'h0);
        step_to(18); chk("po1_e18", 32'(rst_n), 32'h1);
        step_to(22); chk("po1_e22", 32'(rst_n), 32'h3);
        step_to(24); chk("po1_e24", 32'(rst_n), 32'h3);
        reset_n = 1'b0;
        #1;
        chk("abort_rst",   32'(rst_n), 32'h0);
        chk("abort_ready", 32'(ready), 32'h0);
        #2;
        reset_n = 1'b1;
        edge_no = 0;

        // Restarted sequence must show the same edge offsets.
        step_to(17); chk("po_e17", 32'(rst_n), 32'h0);
        step_to(18); chk("po_e18", 32'(rst_n), 32'h1);
        step_to(21); chk("po_e21", 32'(rst_n), 32'h1);
        step_to(22); chk("po_e22", 32'(rst_n), 32'h3);
        step_to(25); chk("po_e25", 32'(rst_n), 32'h3);
        step_to(26); chk("po_e26", 32'(rst_n), 32'h7);
        step_to(29); chk("po_e29", 32'(rst_n), 32'h7);
        step_to(30); chk("po_e30", 32'(rst_n), 32'hF);
        chk("po_rdy30", 32'(ready), 32'h0);
        step_to(31); chk("po_rdy31", 32'(ready), 32'h1);

        // Empty-mask request in READY is ignored.
        req_at(50, 4'b0000);
        chk("m0_ack",   32'(ack),   32'h0);
        chk("m0_rst",   32'(rst_n), 32'hF);
        chk("m0_ready", 32'(ready), 32'h1);

        // Software reset of domains 1 and 3.
        req_at(100, 4'b1010);
        chk("sw_rst100", 32'(rst_n), 32'h5);
        chk("sw_ack100", 32'(ack),   32'h1);
        chk("sw_rdy100", 32'(ready), 32'h0);
        step_to(101);
        chk("sw_ack101", 32'(ack),   32'h0);
        chk("sw_rst101", 32'(rst_n), 32'h5);

        // Request outside READY is ignored and does not disturb timing.
        req_at(110, 4'b1111);
        chk("busy_ack",  32'(ack),   32'h0);
        chk("busy_rst",  32'(rst_n), 32'h5);
        step_to(115); chk("sw_e115", 32'(rst_n), 32'h5);
        step_to(116); chk("sw_e116", 32'(rst_n), 32'h7);
        step_to(119); chk("sw_e119", 32'(rst_n), 32'h7);
        step_to(120); chk("sw_e120", 32'(rst_n), 32'hF);
        chk("sw_rdy120", 32'(ready), 32'h0);
        step_to(121); chk("sw_rdy121", 32'(ready), 32'h1);

        // Minimal configuration: one domain, 3-stage sync, hold/stagger of 1.
        chk("n1_reset", 32'(rst1_n), 32'h0);
        @(negedge clk);
        reset1_n = 1'b1;
        edge_no  = 0;
        step_to(3); chk("n1_e3",     32'(rst1_n), 32'h0);
        step_to(4); chk("n1_e4",     32'(rst1_n), 32'h1);
        chk("n1_rdy4", 32'(ready1), 32'h0);
        step_to(5); chk("n1_rdy5",   32'(ready1), 32'h1);
        step_to(9);
        sw_req1  = 1'b1;
        sw_mask1 = 1'b1;
        step_to(10);
        sw_req1  = 1'b0;
        sw_mask1 = 1'b0;
        chk("n1_sw_rst10", 32'(rst1_n), 32'h0);
        chk("n1_sw_ack10", 32'(ack1),   32'h1);
        step_to(11);
        chk("n1_sw_rst11", 32'(rst1_n), 32'h1);
        chk("n1_sw_ack11", 32'(ack1),   32'h0);
        chk("n1_sw_rdy11", 32'(ready1), 32'h0);
        step_to(12); chk("n1_sw_rdy12", 32'(ready1), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/codma_rst_seq.md
# codma_rst_seq

Parametrised reset sequencer for the CODMA design. Takes the board-level asynchronous active-low reset and produces N_CH per-domain reset outputs. Each output asserts asynchronously, deasserts synchronously and releases in a fixed staggered order. It also supports a masked software reset of selected domains. It sits directly under `top`, between the external `reset_n_i` pin and the DMA engine, channel and bus-interface domains.

## Interface
- N_CH, 4, number of reset domains (1..16); channel 0 releases first
- SYNC_STAGES, 2, reset-release synchroniser depth (>= 2)
- HOLD_CYCLES, 16, cycles all targeted domains stay in reset after the synchronised release (>= 1)
- STAGGER_CYCLES, 4, cycles between consecutive domain releases (>= 1)
- CNT_W, $clog2(HOLD_CYCLES+1) max $clog2(STAGGER_CYCLES+1), internal counter width (derived, not overridden)

- clk_i  input  1  system clock; single clock domain
- reset_n_i  input  1  external reset; asynchronous, active-low
- sw_rst_req_i  input  1  software reset request; sampled on rising `clk_i`, single-cycle pulse
- sw_rst_mask_i  input  N_CH  domains targeted by the request; sampled with `sw_rst_req_i`
- rst_n_o  output  N_CH  per-domain active-low reset
- sw_rst_ack_o  output  1  one-cycle pulse: request accepted
- ready_o  output  1  high when every domain is out of reset and the sequencer is idle

## Operation
- States: SYNC, HOLD, RELEASE, READY.
- Registers `tgt_mask` (N_CH), `rel_idx`, `cnt` (CNT_W).
- Power-on / hardware reset:
  - `reset_n_i` low drives the following asynchronously, with no clock required:
    - all `rst_n_o` = 0
    - `ready_o` = 0, `sw_rst_ack_o` = 0
    - synchroniser cleared
    - state = SYNC, `tgt_mask` = all ones
- SYNC: wait until a 1 has propagated through SYNC_STAGES flops, then go to HOLD with `cnt` = 0.
- HOLD: count HOLD_CYCLES cycles, then go to RELEASE targeting the lowest set bit of `tgt_mask`.
- RELEASE:
  - Drive the targeted channel's `rst_n_o` high.
  - Wait STAGGER_CYCLES, then move to the next higher set bit of `tgt_mask`.
  - After the last set bit has been released, go to READY.
- READY:
  - `ready_o` = 1.
  - A request (`sw_rst_req_i` = 1 with `sw_rst_mask_i` != 0) does the following on the same edge:
    - latches `tgt_mask`
    - drives the masked `rst_n_o` low
    - pulses `sw_rst_ack_o`
    - clears `ready_o`
    - goes to HOLD
- Unmasked domains stay high throughout a software reset.
- Ignored requests produce no ack and no state change:
  - request with mask = 0
  - request outside READY
- Software reset assertion and release are both synchronous. Only `reset_n_i` asserts asynchronously.
- Hardware reset mid-operation (any state) aborts the sequence immediately and restarts from SYNC with all domains.

## Timing
- Edge numbering: edge 1 is the first rising `clk_i` with `reset_n_i` high (setup met).
- Hardware sequence, with E0 = SYNC_STAGES + HOLD_CYCLES:
  - `rst_n_o[k]` rises after edge E0 + k*STAGGER_CYCLES.
  - `ready_o` rises one edge after the last release.
- Software sequence, request sampled at edge S:
  - Masked outputs fall, `sw_rst_ack_o` = 1 and `ready_o` = 0 after edge S; ack falls after S+1.
  - The j-th set mask bit (j = 0, 1, ...) releases after edge S + HOLD_CYCLES + j*STAGGER_CYCLES.
  - `ready_o` rises one edge after the final release.
- No output glitches: all outputs are driven from flops.
- `rst_n_o` bits are never combinationally derived from `sw_rst_req_i`.

## Test plan
- Defaults (N_CH=4, SYNC=2, HOLD=16, STAGGER=4), release `reset_n_i` before edge 1:
  - `rst_n_o` goes 0001 after edge 18, 0011 after 22, 0111 after 26, 1111 after 30.
  - `ready_o` = 1 after edge 31.
- In READY, request with mask 4'b1010 at edge 100:
  - `rst_n_o` = 0101 and ack pulse after 100.
  - Bit 1 rises after 116, bit 3 rises after 120, `ready_o` after 121.
- Ignored requests:
  - Request with mask 0 in READY: no ack, outputs unchanged.
  - Request with mask 4'b1111 at edge 110 of the above software sequence: ignored, timing unchanged.
- Drop `reset_n_i` for 3 ns mid-RELEASE (at edge 24 of the power-on sequence):
  - All `rst_n_o` = 0 and `ready_o` = 0 before the next edge.
  - Full sequence restarts with identical edge offsets.
- N_CH=1, SYNC=3, HOLD=1, STAGGER=1:
  - `rst_n_o` rises after edge 4, `ready_o` after edge 5.
  - A software request at edge 10 releases after edge 11.
